// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings, requester IDs and helpers for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_DATA  = 2'd1;
  localparam logic [1:0] REQ_IO    = 2'd2;
  localparam logic [1:0] GNT_NONE  = 2'd3;

  localparam int unsigned NUM_REQ = 3;

  // Next requester ID in circular (mod 3) order.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == REQ_IO) ? REQ_FETCH : id + 2'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select for the memory port arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin order from ptr; otherwise fixed priority data > fetch > IO.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [1:0] ptr,
`endif
  output logic       valid,
  output logic [1:0] id
);

  assign valid = |req;

`ifdef ARB_ROUND_ROBIN_EN
  // Search ptr+1, ptr+2, ptr; first requesting candidate wins.
  always_comb begin
    logic [1:0] cand;
    id   = GNT_NONE;
    cand = ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = next_id(cand);
      if (req[cand] && (id == GNT_NONE)) begin
        id = cand;
      end
    end
  end
`else
  always_comb begin
    if (req[REQ_DATA])       id = REQ_DATA;
    else if (req[REQ_FETCH]) id = REQ_FETCH;
    else if (req[REQ_IO])    id = REQ_IO;
    else                     id = GNT_NONE;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single unified-memory data port between fetch, load/store and IO/DMA requesters.
// Build option: ARB_ROUND_ROBIN_EN enables round-robin arbitration (default fixed priority).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req,
  input  logic [2:0]          req_we,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*WIDTH-1:0]  req_wdata,
  output logic [2:0]          ack,
  output logic [WIDTH-1:0]    rdata,
  output logic [1:0]          gnt_id,
  output logic                busy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata
);

  arb_state_t        state, state_next;
  logic [1:0]        gnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [WIDTH-1:0]  rdata_q;
  logic              pick_valid;
  logic [1:0]        pick_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0]        ptr_q;

  mem_arb_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .id    (pick_id)
  );
`else
  mem_arb_pick u_pick (
    .req   (req),
    .valid (pick_valid),
    .id    (pick_id)
  );
`endif

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:   if (pick_valid) state_next = ARB_ACCESS;
      ARB_ACCESS: state_next = ARB_RESP;
      ARB_RESP:   state_next = ARB_IDLE;
      default:    state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ARB_IDLE;
      gnt_q   <= GNT_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= REQ_FETCH;
`endif
    end else begin
      state <= state_next;
      if ((state == ARB_IDLE) && pick_valid) begin
        gnt_q   <= pick_id;
        we_q    <= req_we[pick_id];
        addr_q  <= req_addr[pick_id*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata[pick_id*WIDTH +: WIDTH];
`ifdef ARB_ROUND_ROBIN_EN
        ptr_q   <= pick_id;
`endif
      end
      if ((state == ARB_RESP) && !we_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // RAM data only arrives in RESP, so a load bypasses it to rdata there and the register holds it afterwards.
  assign rdata = ((state == ARB_RESP) && !we_q) ? mem_rdata : rdata_q;

  always_comb begin
    ack = '0;
    if (reset && (state == ARB_RESP)) begin
      ack[gnt_q] = 1'b1;
    end
  end

  assign busy      = (state != ARB_IDLE);
  assign gnt_id    = (state == ARB_IDLE) ? GNT_NONE : gnt_q;
  assign mem_en    = reset && (state == ARB_ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
